// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vending_pkg
// Description : Coin and state encodings plus coin values in nickels.
// Revision    : 1.0
// ============================================================================
package vending_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    NICKEL  = 2'd1,
    DIME    = 2'd2,
    QUARTER = 2'd3
  } coin_t;

  typedef enum logic [1:0] {
    ACCEPTING = 2'd0,
    CHANGE    = 2'd1,
    REFUND    = 2'd2,
    DISPENSE  = 2'd3
  } state_t;

  localparam logic [4:0] c_nickel_val  = 5'd1;
  localparam logic [4:0] c_dime_val    = 5'd2;
  localparam logic [4:0] c_quarter_val = 5'd5;

  function automatic logic [4:0] coin_value(input coin_t coin);
    case (coin)
      NICKEL:  return c_nickel_val;
      DIME:    return c_dime_val;
      QUARTER: return c_quarter_val;
      default: return 5'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vending_change_calc.sv
`default_nettype none
// ============================================================================
// Module      : vending_change_calc
// Description : Greedy feasibility check for paying out rem nickels in change.
// Revision    : 1.0
// ============================================================================
module vending_change_calc #(
  parameter int BITS = 4
) (
  input  logic [4:0]      rem,
  input  logic [BITS-1:0] t5,
  input  logic [BITS-1:0] t10,
  input  logic [BITS-1:0] t25,
  output logic            feasible
);

  localparam int W = (BITS > 5) ? BITS : 5;
  localparam logic [W-1:0] c_five = W'(5);
  localparam logic [W-1:0] c_two  = W'(2);

  logic [W-1:0] w_rem;
  logic [W-1:0] w_q;
  logic [W-1:0] w_r1;
  logic [W-1:0] w_d;
  logic [W-1:0] w_left;

  always_comb begin
    w_rem  = W'(rem);
    w_q    = ((w_rem / c_five) < W'(t25)) ? (w_rem / c_five) : W'(t25);
    w_r1   = w_rem - c_five * w_q;
    w_d    = ((w_r1 / c_two) < W'(t10)) ? (w_r1 / c_two) : W'(t10);
    w_left = w_r1 - c_two * w_d;
  end

  assign feasible = (w_left <= W'(t5));

endmodule
`default_nettype wire

// File: rtl/vending_multi.sv
`default_nettype none
// ============================================================================
// Module      : vending_multi
// Description : Multi-product vending controller with cash box and change.
//               Define VENDING_CANCEL_EN to enable customer cancel/refund.
// Revision    : 1.0
// ============================================================================
module vending_multi
  import vending_pkg::*;
#(
  parameter int BITS       = 4,
  parameter int PRICE      = 5,
  parameter int NPROD      = 4,
  parameter int STOCK_BITS = 3,
  parameter int INIT_STOCK = 7,
  localparam int IDW       = (NPROD > 1) ? $clog2(NPROD) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  coin_t            deposit,
  input  logic             select_valid,
  input  logic [IDW-1:0]   select_id,
  input  logic             cancel,
  output coin_t            change,
  output logic             dispense,
  output logic [IDW-1:0]   dispense_id,
  output logic             enable,
  output logic [4:0]       credit,
  output logic [NPROD-1:0] sold_out
);

  localparam logic [4:0]            c_price      = 5'(PRICE);
  localparam logic [STOCK_BITS-1:0] c_init_stock = STOCK_BITS'(INIT_STOCK);

  state_t                r_state;
  state_t                w_state_next;
  logic [4:0]            r_credit;
  logic [4:0]            r_rem;
  logic [BITS-1:0]       r_t5, r_t10, r_t25;
  logic [4:0]            r_l5, r_l10, r_l25;
  logic [STOCK_BITS-1:0] r_stock [NPROD];
  logic [IDW-1:0]        r_id;
  coin_t                 r_change;

  logic       w_box_full, w_accept, w_reject, w_cancel, w_sel_ok, w_take_sel;
  logic       w_feasible, w_l_empty;
  logic [4:0] w_rem_sel;
  coin_t      w_out_coin, w_change_next;

  always_comb begin
    case (deposit)
      NICKEL:  w_box_full = &r_t5;
      DIME:    w_box_full = &r_t10;
      QUARTER: w_box_full = &r_t25;
      default: w_box_full = 1'b0;
    endcase
  end

  assign enable     = (r_state == ACCEPTING) && (r_credit < c_price);
  assign w_accept   = enable && (deposit != NONE) && !w_box_full;
  assign w_reject   = (r_state == ACCEPTING) && (deposit != NONE) && !w_accept;
  assign w_l_empty  = (r_l5 == '0) && (r_l10 == '0) && (r_l25 == '0);
  assign w_rem_sel  = r_credit - c_price;
  assign w_sel_ok   = select_valid && (r_credit >= c_price) &&
                      (32'(select_id) < NPROD) && !sold_out[select_id];
  assign w_take_sel = w_sel_ok && !w_cancel;

`ifdef VENDING_CANCEL_EN
  assign w_cancel = cancel && (r_credit != '0);
`else
  logic w_unused_cancel;
  assign w_unused_cancel = cancel;
  assign w_cancel        = 1'b0;
`endif

  vending_change_calc #(.BITS(BITS)) u_calc (
    .rem      (w_rem_sel),
    .t5       (r_t5),
    .t10      (r_t10),
    .t25      (r_t25),
    .feasible (w_feasible)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ACCEPTING;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCEPTING: begin
        if (w_cancel)                 w_state_next = REFUND;
        else if (w_take_sel) begin
          if (w_rem_sel == '0)        w_state_next = DISPENSE;
          else if (w_feasible)        w_state_next = CHANGE;
          else                        w_state_next = REFUND;
        end
      end
      CHANGE:   if (r_rem == coin_value(w_out_coin)) w_state_next = DISPENSE;
      REFUND:   if (w_l_empty) w_state_next = ACCEPTING;
      DISPENSE: w_state_next = ACCEPTING;
      default:  w_state_next = ACCEPTING;
    endcase
  end

  // Payout coin chosen greedily in CHANGE, largest-first from the transaction in REFUND.
  always_comb begin
    w_out_coin    = NONE;
    w_change_next = NONE;
    case (r_state)
      ACCEPTING: w_change_next = w_reject ? deposit : NONE;
      CHANGE: begin
        if (r_rem >= 5'd5 && r_t25 != '0)      w_out_coin = QUARTER;
        else if (r_rem >= 5'd2 && r_t10 != '0) w_out_coin = DIME;
        else if (r_rem != '0)                  w_out_coin = NICKEL;
        w_change_next = w_out_coin;
      end
      REFUND: begin
        if (r_l25 != '0)      w_out_coin = QUARTER;
        else if (r_l10 != '0) w_out_coin = DIME;
        else if (r_l5 != '0)  w_out_coin = NICKEL;
        w_change_next = w_out_coin;
      end
      default: w_change_next = NONE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_credit <= '0;
      r_rem    <= '0;
      r_t5     <= '0;
      r_t10    <= '0;
      r_t25    <= '0;
      r_l5     <= '0;
      r_l10    <= '0;
      r_l25    <= '0;
      r_id     <= '0;
      r_change <= NONE;
      for (int i = 0; i < NPROD; i++) r_stock[i] <= c_init_stock;
    end else begin
      r_change <= w_change_next;
      case (r_state)
        ACCEPTING: begin
          if (w_accept) begin
            r_credit <= r_credit + coin_value(deposit);
            case (deposit)
              NICKEL:  begin r_t5  <= r_t5  + 1'b1; r_l5  <= r_l5  + 1'b1; end
              DIME:    begin r_t10 <= r_t10 + 1'b1; r_l10 <= r_l10 + 1'b1; end
              QUARTER: begin r_t25 <= r_t25 + 1'b1; r_l25 <= r_l25 + 1'b1; end
              default: ;
            endcase
          end
          if (w_take_sel) begin
            r_id  <= select_id;
            r_rem <= w_rem_sel;
          end
        end
        CHANGE: begin
          r_rem <= r_rem - coin_value(w_out_coin);
          case (w_out_coin)
            NICKEL:  if (r_t5  != '0) r_t5  <= r_t5  - 1'b1;
            DIME:    if (r_t10 != '0) r_t10 <= r_t10 - 1'b1;
            QUARTER: if (r_t25 != '0) r_t25 <= r_t25 - 1'b1;
            default: ;
          endcase
        end
        REFUND: begin
          case (w_out_coin)
            NICKEL: begin
              r_l5 <= r_l5 - 1'b1;
              if (r_t5 != '0) r_t5 <= r_t5 - 1'b1;
            end
            DIME: begin
              r_l10 <= r_l10 - 1'b1;
              if (r_t10 != '0) r_t10 <= r_t10 - 1'b1;
            end
            QUARTER: begin
              r_l25 <= r_l25 - 1'b1;
              if (r_t25 != '0) r_t25 <= r_t25 - 1'b1;
            end
            default: ;
          endcase
          if (w_l_empty) r_credit <= '0;
        end
        DISPENSE: begin
          if (r_stock[r_id] != '0) r_stock[r_id] <= r_stock[r_id] - 1'b1;
          r_credit <= '0;
          r_l5     <= '0;
          r_l10    <= '0;
          r_l25    <= '0;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NPROD; g++) begin : g_sold_out
    assign sold_out[g] = (r_stock[g] == '0);
  end

  assign change      = r_change;
  assign dispense    = (r_state == DISPENSE);
  assign dispense_id = r_id;
  assign credit      = r_credit;

endmodule
`default_nettype wire

// File: tb/tb_vending_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_vending_multi
// Description : Directed self-checking bench for vending_multi (default parameters).
// Revision    : 1.0
// ============================================================================
module tb_vending_multi;
  import vending_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  coin_t      deposit;
  logic       select_valid;
  logic [1:0] select_id;
  logic       cancel;
  coin_t      change;
  logic       dispense;
  logic [1:0] dispense_id;
  logic       enable;
  logic [4:0] credit;
  logic [3:0] sold_out;

  int n_vec = 0;
  int n_err = 0;

  vending_multi dut (
    .clock        (clock),
    .reset        (reset),
    .deposit      (deposit),
    .select_valid (select_valid),
    .select_id    (select_id),
    .cancel       (cancel),
    .change       (change),
    .dispense     (dispense),
    .dispense_id  (dispense_id),
    .enable       (enable),
    .credit       (credit),
    .sold_out     (sold_out)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input coin_t c);
    deposit = c;
    tick();
    deposit = NONE;
  endtask

  task automatic pick(input logic [1:0] id);
    select_valid = 1'b1;
    select_id    = id;
    tick();
    select_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    deposit      = NONE;
    select_valid = 1'b0;
    select_id    = 2'd0;
    cancel       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check_val("rst_change", change, NONE);
    check_val("rst_credit", credit, 0);
    check_val("rst_enable", enable, 1);
    check_val("rst_dispense", dispense, 0);
    check_val("rst_dispense_id", dispense_id, 0);
    check_val("rst_sold_out", sold_out, 0);

    // Exact payment: quarter buys product 2 without change
    put(QUARTER);
    check_val("q_credit", credit, 5);
    check_val("q_enable", enable, 0);
    pick(2'd2);
    check_val("q_dispense", dispense, 1);
    check_val("q_dispense_id", dispense_id, 2);
    check_val("q_change_disp", change, NONE);
    tick();
    check_val("q_dispense_end", dispense, 0);
    check_val("q_credit_end", credit, 0);
    check_val("q_change_end", change, NONE);
    check_val("q_stock2", dut.r_stock[2], 6);

    // Credit 9 pays out two dimes
    do_reset();
    put(DIME);
    put(DIME);
    put(QUARTER);
    check_val("ddq_credit", credit, 9);
    pick(2'd0);
    check_val("ddq_change0", change, NONE);
    tick();
    check_val("ddq_change1", change, DIME);
    check_val("ddq_disp1", dispense, 0);
    tick();
    check_val("ddq_change2", change, DIME);
    check_val("ddq_disp2", dispense, 1);
    check_val("ddq_id", dispense_id, 0);
    tick();
    check_val("ddq_change3", change, NONE);
    check_val("ddq_credit_end", credit, 0);

    // Three dimes with no nickels: change infeasible, full refund
    do_reset();
    put(DIME);
    put(DIME);
    put(DIME);
    check_val("ref_credit", credit, 6);
    pick(2'd1);
    check_val("ref_change0", change, NONE);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("ref_dime", change, DIME);
      check_val("ref_no_disp", dispense, 0);
    end
    tick();
    check_val("ref_change_end", change, NONE);
    check_val("ref_credit_end", credit, 0);
    check_val("ref_enable_end", enable, 1);
    check_val("ref_stock1", dut.r_stock[1], 7);

    // Cancel after nickel and dime
    do_reset();
    put(NICKEL);
    put(DIME);
    check_val("can_credit", credit, 3);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
`ifdef VENDING_CANCEL_EN
    check_val("can_change0", change, NONE);
    tick();
    check_val("can_dime", change, DIME);
    tick();
    check_val("can_nickel", change, NICKEL);
    tick();
    check_val("can_change_end", change, NONE);
    check_val("can_credit_end", credit, 0);
    check_val("can_enable_end", enable, 1);
`else
    check_val("nocan_change", change, NONE);
    check_val("nocan_credit", credit, 3);
    check_val("nocan_enable", enable, 1);
`endif

    // Sell out product 3, then try once more
    do_reset();
    for (int i = 0; i < 7; i++) begin
      put(QUARTER);
      pick(2'd3);
      check_val("so_dispense", dispense, 1);
      tick();
    end
    check_val("so_sold_out", sold_out, 4'b1000);
    put(QUARTER);
    check_val("so_credit", credit, 5);
    put(DIME);
    check_val("so_reject_dime", change, DIME);
    check_val("so_reject_credit", credit, 5);
    pick(2'd3);
    check_val("so_no_dispense", dispense, 0);
    check_val("so_credit_hold", credit, 5);
    check_val("so_enable_low", enable, 0);
    tick();
    check_val("so_still_idle", dispense, 0);

    // Fill the nickel box, then a further nickel bounces
    do_reset();
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 5; k++) put(NICKEL);
      pick(2'd0);
      tick();
    end
    check_val("full_t5", dut.r_t5, 15);
    check_val("full_credit0", credit, 0);
    put(NICKEL);
    check_val("full_change", change, NICKEL);
    check_val("full_credit", credit, 0);
    check_val("full_t5_hold", dut.r_t5, 15);
    tick();
    check_val("full_change_end", change, NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
